// File: rtl/hmm_pkg.sv
// Shared types and defaults for the HMM-Viterbi front end.
package hmm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_QUIET = 3'd4
  } spi_state_t;

  localparam int SPI_CLK_DIV      = 2;
  localparam int SPI_QUIET_CYCLES = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_shift_chan.sv
// One ADC channel: frame shift register (MSB first) and leading-zero check.
module spi_shift_chan #(
  parameter int FRAME_BITS = 16,
  parameter int LEAD_ZEROS = 4,
  parameter int DATA_BITS  = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 shift_en_i,
  input  logic                 sdata_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 lead_err_o
);

  logic [FRAME_BITS-1:0] sr_q, sr_d;

  // Shift one bit in on each sampling strobe; hold otherwise.
  always_comb begin
    sr_d = sr_q;
    if (shift_en_i) sr_d = {sr_q[FRAME_BITS-2:0], sdata_i};
  end

  // Shift register state; reset drops any partial frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign data_o = sr_q[FRAME_BITS-1-LEAD_ZEROS -: DATA_BITS];

  if (LEAD_ZEROS > 0) begin : g_lead
    assign lead_err_o = |sr_q[FRAME_BITS-1 -: LEAD_ZEROS];
  end else begin : g_nolead
    assign lead_err_o = 1'b0;
  end

endmodule

// File: rtl/spi_adc_sampler.sv
// Serial ADC front end: generates P_SCLK/P_nCS frames, captures CHANNELS
// data lines and presents aligned samples on a valid/ready interface.
module spi_adc_sampler
  import hmm_pkg::*;
#(
  parameter int CLK_DIV      = SPI_CLK_DIV,
  parameter int FRAME_BITS   = 16,
  parameter int LEAD_ZEROS   = 4,
  parameter int DATA_BITS    = 12,
  parameter int CHANNELS     = 1,
  parameter int QUIET_CYCLES = SPI_QUIET_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          continuous,
  input  logic [CHANNELS-1:0]           P_SDATA,
  output logic                          P_SCLK,
  output logic                          P_nCS,
  output logic [CHANNELS*DATA_BITS-1:0] sample_data,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic                          busy
);

  localparam int CW = $clog2(max2(CLK_DIV, QUIET_CYCLES) + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

  spi_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;     // divider / quiet counter
  logic [BW-1:0] bit_q, bit_d;     // bit period within SHIFT
  logic          phase_q, phase_d; // 0 = SCLK low half, 1 = high half
  logic          sclk_q, sclk_d;
  logic          ncs_q, ncs_d;
  logic          shift_en, xfer;

  logic [CHANNELS*DATA_BITS-1:0] chan_data;
  logic [CHANNELS-1:0]           chan_err;

  logic [CHANNELS*DATA_BITS-1:0] data_q, data_d;
  logic                          valid_q, valid_d;
  logic                          err_q, err_d;
  logic                          ovr_q, ovr_d;

  // State register; SCLK/nCS are registered so the pins never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      sclk_q  <= 1'b1;
      ncs_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
    end
  end

  // Next-state: frame sequencing and the divider/bit counters.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (start || continuous) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
        end else cnt_d = cnt_q + CW'(1);
      end
      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!phase_q) phase_d = 1'b1;
          else begin
            phase_d = 1'b0;
            if (bit_q == BIT_LAST) state_d = ST_HOLD;
            else                   bit_d   = bit_q + BW'(1);
          end
        end else cnt_d = cnt_q + CW'(1);
      end
      ST_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = ST_QUIET;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      ST_QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          state_d = continuous ? ST_SETUP : ST_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: pin levels follow the next state; strobes decode the current one.
  always_comb begin
    ncs_d    = (state_d == ST_IDLE) || (state_d == ST_QUIET);
    sclk_d   = !((state_d == ST_SHIFT) && !phase_d);
    shift_en = (state_q == ST_SHIFT) && !phase_q && (cnt_q == DIV_LAST);
    xfer     = (state_q == ST_HOLD) && (cnt_q == DIV_LAST);
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    spi_shift_chan #(
      .FRAME_BITS (FRAME_BITS),
      .LEAD_ZEROS (LEAD_ZEROS),
      .DATA_BITS  (DATA_BITS)
    ) u_chan (
      .clk_i      (clk),
      .rst_i      (rst),
      .shift_en_i (shift_en),
      .sdata_i    (P_SDATA[c]),
      .data_o     (chan_data[c*DATA_BITS +: DATA_BITS]),
      .lead_err_o (chan_err[c])
    );
  end

  // Output register: a transfer always lands; it flags overrun when it
  // replaces a sample the consumer has not taken on this same edge.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    ovr_d   = ovr_q && !overrun_clr;
    if (xfer) begin
      data_d  = chan_data;
      err_d   = |chan_err;
      valid_d = 1'b1;
      if (valid_q && !sample_ready) ovr_d = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign P_SCLK       = sclk_q;
  assign P_nCS        = ncs_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  assign overrun      = ovr_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
